// File: rtl/pt2262_encoder_param.sv
// pt2262_encoder_param: parametrised PT2262-style tri-state remote-control frame encoder
module pt2262_encoder_param #(
  parameter int N_ADDR = 8,
  parameter int N_DATA = 4,
  parameter int CLK_DIV = 250,
  parameter int N_REPEAT = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                cont,
  input  logic [N_ADDR-1:0]                   addr_val,
  input  logic [N_ADDR-1:0]                   addr_float,
  input  logic [(N_DATA > 0 ? N_DATA : 1)-1:0] data,
  output logic                                busy,
  output logic                                done,
  output logic                                sync,
  output logic                                cod_o
);
  localparam int DW = N_DATA > 0 ? N_DATA : 1;
  localparam int NS = N_ADDR + N_DATA;
  localparam int SW = $clog2(NS + 1);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, SYM, SYNC, DONE} state_t;
  state_t            state_q, state_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [6:0]        chip_q, chip_d;
  logic [SW-1:0]     sym_q, sym_d;
  logic [7:0]        rep_q, rep_d;
  logic [N_ADDR-1:0] av_q, av_d, af_q, af_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic              busy_q, busy_d, done_q, done_d, sync_q, sync_d, cod_q, cod_d;
  logic              tick, near_end, more, bit_v, bit_f, hi;
  logic [8:0]        rep_inc;
  logic [N_ADDR+DW-1:0] vals, flts;
  always_comb begin
    tick = pre_q == PW'(CLK_DIV - 1);
    near_end = CLK_DIV == 1 ? chip_q == 7'd126 : chip_q == 7'd127 && pre_q == PW'(CLK_DIV - 2);
    rep_inc = {1'b0, rep_q} + 9'd1;
    more = rep_inc < 9'(N_REPEAT) || cont;
    state_d = state_q;
    pre_d = pre_q;
    chip_d = chip_q;
    sym_d = sym_q;
    rep_d = rep_q;
    av_d = av_q;
    af_d = af_q;
    dat_d = dat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          pre_d = '0;
          rep_d = '0;
        end
      end
      LOAD: begin
        av_d = addr_val;
        af_d = addr_float;
        dat_d = data;
        pre_d = '0;
        chip_d = '0;
        sym_d = '0;
        state_d = SYM;
      end
      SYM: begin
        pre_d = tick ? '0 : pre_q + PW'(1);
        if (tick) begin
          chip_d = chip_q == 7'd31 ? 7'd0 : chip_q + 7'd1;
          if (chip_q == 7'd31) begin
            sym_d = sym_q + SW'(1);
            if (sym_q == SW'(NS - 1)) begin
              sym_d = '0;
              state_d = SYNC;
            end
          end
        end
      end
      SYNC: begin
        pre_d = tick ? '0 : pre_q + PW'(1);
        if (tick) chip_d = chip_q == 7'd127 ? 7'd0 : chip_q + 7'd1;
        if (near_end) begin
          rep_d = more && rep_inc >= 9'(N_REPEAT) ? 8'd0 : rep_inc[7:0];
          if (more) state_d = LOAD;
        end else if (tick && chip_q == 7'd127) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        pre_d = '0;
        chip_d = '0;
        rep_d = '0;
      end
      default: state_d = IDLE;
    endcase
    vals = {dat_d, av_d};
    flts = {DW'(0), af_d};
    bit_v = 1'(vals >> sym_d);
    bit_f = 1'(flts >> sym_d);
    hi = chip_d[3:0] < (chip_d[4] ? ((bit_f || bit_v) ? 4'd12 : 4'd4) : ((bit_f || !bit_v) ? 4'd4 : 4'd12));
    cod_d = state_d == SYM ? hi : state_d == SYNC && chip_d < 7'd4;
    sync_d = state_d == SYNC || (state_d == LOAD && state_q == SYNC);
    busy_d = state_d == LOAD || state_d == SYM || state_d == SYNC;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pre_q <= '0;
      chip_q <= '0;
      sym_q <= '0;
      rep_q <= '0;
      av_q <= '0;
      af_q <= '0;
      dat_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sync_q <= 1'b0;
      cod_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      chip_q <= chip_d;
      sym_q <= sym_d;
      rep_q <= rep_d;
      av_q <= av_d;
      af_q <= af_d;
      dat_q <= dat_d;
      busy_q <= busy_d;
      done_q <= done_d;
      sync_q <= sync_d;
      cod_q <= cod_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sync = sync_q;
  assign cod_o = cod_q;
endmodule
